mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the fetch requester, the data requester,
// the shared memory and the arbiter that sits between them.
//   slave  : arbiter view (requests and memory response in; acks, read data
//            and memory strobes out)
//   master : requester/memory side view (the mirror image of slave)
// Parameter n sets the address and data width.
interface mem_port_arbiter_if #(
    parameter int n = 16
);
    // instruction-fetch port
    logic           i_req;
    logic [n-1:0]   i_addr;
    logic           i_ack;
    logic [n-1:0]   i_rdata;
    // data-stage port
    logic           d_req;
    logic           d_we;
    logic [n-1:0]   d_addr;
    logic [n-1:0]   d_wdata;
    logic           d_ack;
    logic [n-1:0]   d_rdata;
    // shared memory port
    logic           mem_en;
    logic           mem_we;
    logic [n-1:0]   mem_addr;
    logic [n-1:0]   mem_wdata;
    logic [n-1:0]   mem_rdata;
    logic           mem_ready;
    // address-mux select, 0 = fetch owns the memory, 1 = data owns it
    logic           sel;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, sel
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port. Data accesses win over
// instruction fetch, except that after STARVE_MAX consecutive data grants
// issued while fetch was waiting, fetch is granted once. Every access runs
// IDLE -> BUSY_x -> IDLE; the memory may stretch BUSY_x indefinitely by
// holding mem_ready low. Completion is reported with a one-cycle ack and
// registered read data on the owning port.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (fetch port, data port, memory port, sel)
// Parameters:
//   n          : address/data width
//   STARVE_MAX : data grants allowed back to back while fetch waits
module mem_port_arbiter #(
    parameter int n          = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            grant_i;
    logic            grant_d;
    logic            done;

    logic [CW-1:0]   starve_cnt_reg;
    logic [n-1:0]    mem_addr_reg;
    logic [n-1:0]    mem_wdata_reg;
    logic            mem_we_reg;
    logic            sel_reg;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state and grant/complete strobes
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // data wins unless fetch has already been passed over
                // STARVE_MAX times in a row; mem_ready is not looked at here
                if (bus.d_req && (!bus.i_req || (starve_cnt_reg < STARVE_LIM))) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (bus.i_req) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // requests are not looked at: a dropped request still completes
                if (bus.mem_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Memory-side registers: loaded only on a grant, so they stay frozen
    // for the whole BUSY state.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            sel_reg        <= 1'b0;
        end else if (grant_d) begin
            mem_addr_reg  <= bus.d_addr;
            mem_wdata_reg <= bus.d_wdata;
            mem_we_reg    <= bus.d_we;
            sel_reg       <= 1'b1;
            // only a grant that overtakes a waiting fetch counts
            if (bus.i_req && (starve_cnt_reg < STARVE_LIM)) begin
                starve_cnt_reg <= starve_cnt_reg + CW'(1);
            end
        end else if (grant_i) begin
            mem_addr_reg   <= bus.i_addr;
            mem_we_reg     <= 1'b0;
            sel_reg        <= 1'b0;
            starve_cnt_reg <= '0;
        end
    end

    // ---------------------------------------------------------------
    // Per-port completion: port 0 is fetch, port 1 is data. sel_reg
    // names the owner during BUSY, so only one port can ack at a time and
    // the other port's read data register holds.
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic OWNER = 1'(gi);
            logic            ack_reg;
            logic [n-1:0]    rdata_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= done && (sel_reg == OWNER);
                    if (done && (sel_reg == OWNER)) begin
                        rdata_reg <= bus.mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign bus.mem_en    = (state_reg != IDLE);
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.sel       = sel_reg;
    assign bus.i_ack     = g_port[0].ack_reg;
    assign bus.i_rdata   = g_port[0].rdata_reg;
    assign bus.d_ack     = g_port[1].ack_reg;
    assign bus.d_rdata   = g_port[1].rdata_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a random
// traffic run, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int N  = 16;
    localparam int SM = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.n(N)) bus();

    mem_port_arbiter #(.n(N), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the memory, what was latched at grant,
    // how many times fetch has been overtaken, and what each port's
    // ack/read data should show after the edge.
    int           m_owner;   // 0 none, 1 fetch, 2 data
    int           m_starve;
    logic [N-1:0] m_addr, m_wdata, m_i_rdata, m_d_rdata;
    logic         m_we, m_sel, m_i_ack, m_d_ack;

    task automatic model_reset();
        m_owner   = 0;
        m_starve  = 0;
        m_addr    = '0;
        m_wdata   = '0;
        m_i_rdata = '0;
        m_d_rdata = '0;
        m_we      = 1'b0;
        m_sel     = 1'b0;
        m_i_ack   = 1'b0;
        m_d_ack   = 1'b0;
    endtask

    // Applies one rising edge worth of the arbitration rules to the model.
    task automatic model_edge();
        m_i_ack = 1'b0;
        m_d_ack = 1'b0;
        if (m_owner == 0) begin
            if (bus.d_req && (!bus.i_req || m_starve < SM)) begin
                m_owner = 2;
                m_addr  = bus.d_addr;
                m_wdata = bus.d_wdata;
                m_we    = bus.d_we;
                m_sel   = 1'b1;
                if (bus.i_req) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
            end else if (bus.i_req) begin
                m_owner  = 1;
                m_addr   = bus.i_addr;
                m_we     = 1'b0;
                m_sel    = 1'b0;
                m_starve = 0;
            end
        end else if (bus.mem_ready) begin
            if (m_owner == 1) begin
                m_i_ack   = 1'b1;
                m_i_rdata = bus.mem_rdata;
            end else begin
                m_d_ack   = 1'b1;
                m_d_rdata = bus.mem_rdata;
            end
            m_owner = 0;
        end
    endtask

    // Inputs are driven at the falling edge; one call advances one clock
    // and returns at the next falling edge, where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", bus.sel); end
        checks++; if ({bus.i_ack, bus.d_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {bus.i_ack, bus.d_ack}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
        checks++; if ({bus.i_rdata, bus.d_rdata} !== '0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.i_rdata, bus.d_rdata); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_fetch_only();
        bus.i_req = 1; bus.i_addr = 16'h0040;
        bus.mem_ready = 1; bus.mem_rdata = 16'h5A5A;
        tick();
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL fetch_mem_en: got %b expected 1", bus.mem_en); end
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("FAIL fetch_sel: got %b expected 0", bus.sel); end
        checks++; if (bus.mem_addr !== 16'h0040) begin errors++; $display("FAIL fetch_addr: got %h expected 0040", bus.mem_addr); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.i_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack: got %b expected 0", bus.i_ack); end
        tick();
        checks++; if (bus.i_ack !== 1'b1) begin errors++; $display("FAIL fetch_ack: got %b expected 1", bus.i_ack); end
        checks++; if (bus.i_rdata !== 16'h5A5A) begin errors++; $display("FAIL fetch_rdata: got %h expected 5a5a", bus.i_rdata); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL fetch_bubble: got %b expected 0", bus.mem_en); end
        checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL fetch_d_ack: got %b expected 0", bus.d_ack); end
        bus.i_req = 0; bus.mem_ready = 0;
        tick();
        checks++; if (bus.i_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse: got %b expected 0", bus.i_ack); end
        $display("txn fetch addr=0040 rdata=%h", bus.i_rdata);
    endtask

    task automatic test_data_write_wait();
        int acks = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h1234; bus.d_wdata = 16'hBEEF;
        bus.mem_ready = 0;
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++; if ({bus.mem_en, bus.mem_we, bus.sel} !== 3'b111) begin errors++; $display("FAIL write_strobes c%0d: got %b expected 111", c, {bus.mem_en, bus.mem_we, bus.sel}); end
            checks++; if ({bus.mem_addr, bus.mem_wdata} !== {16'h1234, 16'hBEEF}) begin errors++; $display("FAIL write_bus c%0d: got %h/%h expected 1234/beef", c, bus.mem_addr, bus.mem_wdata); end
            checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL write_early_ack c%0d: got %b expected 0", c, bus.d_ack); end
            if (c == 3) bus.mem_ready = 1;
            tick();
        end
        if (bus.d_ack) acks++;
        bus.d_req = 0; bus.mem_ready = 0;
        tick();
        if (bus.d_ack) acks++;
        checks++; if (acks != 1) begin errors++; $display("FAIL write_ack_count: got %0d expected 1", acks); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL write_idle: got %b expected 0", bus.mem_en); end
        $display("txn data write addr=1234 wdata=beef");
    endtask

    task automatic test_starvation();
        logic [0:7] pat = 8'b11101110;  // 1 = data ack, 0 = fetch ack
        int n_acks = 0;
        bus.i_req = 1; bus.i_addr = 16'h0100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0200;
        bus.mem_ready = 1;
        for (int c = 0; c < 16; c++) begin
            bus.mem_rdata = 16'($urandom);
            tick();
            checks++; if (bus.i_ack && bus.d_ack) begin errors++; $display("FAIL starve_both_acks c%0d: got 11 expected at most one", c); end
            if (bus.i_ack || bus.d_ack) begin
                if (n_acks < 8) begin
                    checks++; if (bus.d_ack !== pat[n_acks]) begin errors++; $display("FAIL starve_order #%0d: got d_ack=%b expected %b", n_acks, bus.d_ack, pat[n_acks]); end
                end
                $display("txn grant #%0d %s", n_acks, bus.d_ack ? "D" : "I");
                n_acks++;
            end
        end
        checks++; if (n_acks != 8) begin errors++; $display("FAIL starve_ack_count: got %0d expected 8", n_acks); end
        bus.i_req = 0; bus.d_req = 0; bus.mem_ready = 0;
        tick();
    endtask

    task automatic test_drop_and_idle_ready();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0777; bus.mem_ready = 0;
        tick();
        bus.d_req = 0;
        tick();
        checks++; if ({bus.mem_en, bus.sel, bus.d_ack} !== 3'b110) begin errors++; $display("FAIL drop_busy: got %b expected 110", {bus.mem_en, bus.sel, bus.d_ack}); end
        bus.mem_ready = 1; bus.mem_rdata = 16'hC3C3;
        tick();
        checks++; if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL drop_ack: got %b expected 1", bus.d_ack); end
        checks++; if (bus.d_rdata !== 16'hC3C3) begin errors++; $display("FAIL drop_rdata: got %h expected c3c3", bus.d_rdata); end
        checks++; if (bus.i_rdata !== m_i_rdata) begin errors++; $display("FAIL drop_i_rdata_hold: got %h expected %h", bus.i_rdata, m_i_rdata); end
        $display("txn data read after drop rdata=%h", bus.d_rdata);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if ({bus.i_ack, bus.d_ack, bus.mem_en} !== 3'b000) begin errors++; $display("FAIL idle_ready c%0d: got %b expected 000", c, {bus.i_ack, bus.d_ack, bus.mem_en}); end
        end
        bus.mem_ready = 0;
    endtask

    task automatic test_reset_mid_access();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h2222; bus.d_wdata = 16'h1111;
        bus.mem_ready = 0;
        tick();
        checks++; if ({bus.mem_en, bus.sel, bus.mem_we} !== 3'b111) begin errors++; $display("FAIL rstmid_busy: got %b expected 111", {bus.mem_en, bus.sel, bus.mem_we}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_en, bus.sel, bus.mem_we, bus.i_ack, bus.d_ack} !== 5'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 00000", {bus.mem_en, bus.sel, bus.mem_we, bus.i_ack, bus.d_ack}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== '0) begin errors++; $display("FAIL rstmid_data: got %h/%h/%h/%h expected all 0", bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata); end
        model_reset();
        bus.d_req = 0; bus.mem_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if ({bus.d_ack, bus.mem_en} !== 2'b00) begin errors++; $display("FAIL rstmid_no_ack c%0d: got %b expected 00", c, {bus.d_ack, bus.mem_en}); end
        end
        bus.mem_ready = 0;
        $display("txn reset during data access");
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            // requesters: start a new request when idle or just acked,
            // otherwise hold request and payload steady
            if (!bus.i_req || m_i_ack) begin
                bus.i_req  = ($urandom_range(0, 2) != 0);
                bus.i_addr = 16'($urandom);
            end
            if (!bus.d_req || m_d_ack) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = 1'($urandom);
                bus.d_addr  = 16'($urandom);
                bus.d_wdata = 16'($urandom);
            end
            bus.mem_ready = ($urandom_range(0, 1) == 1);
            bus.mem_rdata = 16'($urandom);
            tick();
            checks++; if (bus.mem_en !== (m_owner != 0)) begin errors++; $display("FAIL rnd_mem_en c%0d: got %b expected %b", c, bus.mem_en, (m_owner != 0)); end
            checks++; if ({bus.i_ack, bus.d_ack} !== {m_i_ack, m_d_ack}) begin errors++; $display("FAIL rnd_acks c%0d: got %b expected %b", c, {bus.i_ack, bus.d_ack}, {m_i_ack, m_d_ack}); end
            checks++; if ({bus.i_rdata, bus.d_rdata} !== {m_i_rdata, m_d_rdata}) begin errors++; $display("FAIL rnd_rdata c%0d: got %h/%h expected %h/%h", c, bus.i_rdata, bus.d_rdata, m_i_rdata, m_d_rdata); end
            if (m_owner != 0) begin
                checks++; if ({bus.sel, bus.mem_we, bus.mem_addr} !== {m_sel, m_we, m_addr}) begin errors++; $display("FAIL rnd_grant c%0d: got sel=%b we=%b addr=%h expected sel=%b we=%b addr=%h", c, bus.sel, bus.mem_we, bus.mem_addr, m_sel, m_we, m_addr); end
                if (m_owner == 2 && m_we) begin
                    checks++; if (bus.mem_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, bus.mem_wdata, m_wdata); end
                end
            end
            if (m_i_ack) $display("txn rnd fetch rdata=%h", m_i_rdata);
            if (m_d_ack) $display("txn rnd data rdata=%h", m_d_rdata);
        end
        bus.i_req = 0; bus.d_req = 0; bus.mem_ready = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fetch_only();
        test_data_write_wait();
        test_starvation();
        test_drop_and_idle_ready();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
